rv_iopmp_dl_seq: RTL and testbench
==================================

// Module: rv_iopmp_dl_seq
// PURPOSE
//  Multi-cycle window sequencer in front of the source-enforcement decision logic (rv_iopmp_dl_se).
//  Accepts one transaction at a time and steps entry_offset through the entry table in
//  windows of NUMBER_INSTANCES. Stops at the first window that yields a decision.
//  Returns a registered allow/error response over a valid/ready handshake.
//  Sits between the request front-end and the shared entry matcher/decision logic pair.
// PARAMETERS
//  NUMBER_ENTRIES    32  total entries; multiple of NUMBER_INSTANCES, <= 512
//  NUMBER_INSTANCES   8  entries evaluated per cycle (window width)
// PORTS
//  clk_i                  in   1   clock
//  rst_ni                 in   1   asynchronous active-low reset
//  enable_i               in   1   IOPMP global enable; sampled at request acceptance
//  req_valid_i            in   1   transaction request valid
//  req_ready_o            out  1   sequencer idle, can accept
//  req_access_i           in   access_t  access type (rv_iopmp_pkg)
//  dl_enable_o            out  1   to decision logic enable_i
//  dl_entry_offset_o      out  9   to matcher + decision logic entry_offset_i
//  dl_access_o            out  access_t  held access type to decision logic
//  dl_allow_i             in   1   decision logic allow_transaction_o (same-cycle, combinational)
//  dl_err_i               in   1   decision logic err_transaction_o
//  dl_err_type_i          in   3   decision logic err_type_o
//  dl_err_index_i         in   16  decision logic err_entry_index_o
//  rsp_valid_o            out  1   response valid
//  rsp_ready_i            in   1   response accepted
//  rsp_allow_o            out  1   transaction permitted
//  rsp_err_o              out  1   error record must be logged
//  rsp_err_type_o         out  3   error type
//  rsp_err_index_o        out  16  faulting entry index
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; offset=0; all rsp_* = 0; dl_enable_o=0; req_ready_o=1.
//  - FSM states: IDLE, SCAN, RESP.
//  - IDLE: req_ready_o=1. On req_valid_i, latch access type and enable_i.
//    - Latched enable=1: offset=0, go to SCAN.
//    - Latched enable=0 (bypass): load rsp allow=1, err=0, type=0, index=0; go to RESP.
//  - SCAN: req_ready_o=0. dl_enable_o=1. dl_entry_offset_o = registered offset.
//    - Window decides (dl_allow_i | dl_err_i): register allow/err/type/index from the DL inputs; go to RESP.
//    - No decision, offset != LAST (LAST = NUMBER_ENTRIES-NUMBER_INSTANCES): offset += NUMBER_INSTANCES; stay in SCAN.
//    - No decision at offset == LAST (defensive; the DL normally reports not-hit here):
//      force allow=0, err=1, type=ERR_NOT_HIT (3'h5), index=0; go to RESP.
//  - RESP: rsp_valid_o=1. rsp_* held stable until rsp_ready_i; on handshake go to IDLE, clear rsp_valid_o.
//  - Latency:
//    - Request accepted in cycle N, decision in window k (0-based): rsp_valid_o first high in cycle N+k+2.
//    - Bypass: rsp_valid_o high in cycle N+1.
//    - Worst case: N + NUMBER_ENTRIES/NUMBER_INSTANCES + 1.
//  - Back-to-back: a new request is accepted at the earliest in the cycle after the RESP handshake.
//    req_ready_o is 0 in SCAN and RESP.
//  - enable_i changes after acceptance have no effect on the in-flight scan.
//  - dl_* outputs are 0 / offset 0 outside SCAN.
//  - Offset arithmetic is 9-bit unsigned and never exceeds LAST. No wrap-around.
//  - Single-window config (NUMBER_ENTRIES==NUMBER_INSTANCES): LAST=0, so the scan is always one cycle.
// STRUCTURE
//  - rv_iopmp_pkg: seq_state_e {IDLE,SCAN,RESP}; ERR_NOT_HIT=3'h5 (shared with rv_iopmp_dl_se).
//    Reuse the existing access_t.
//  - No sub-module. The parent instantiates the matcher and rv_iopmp_dl_se and wires them to the dl_* ports.
//  - One always_ff (async reset) for state/offset/latches/response; one always_comb for next-state and dl_* drive.
// TESTING
//  1. enable_i=0, READ request -> rsp_valid_o at N+1, allow=1, err=0; req_ready_o=0 until rsp handshake.
//  2. NE=32/NI=8, DL allows in window 2 -> dl_entry_offset_o sequence 0,8,16;
//     rsp allow=1, err=0 at N+4.
//  3. DL denies WRITE at window 1, index 11 -> rsp allow=0, err=1, type=2, index=11 at N+3.
//  4. No match in any window; DL reports type 5 at offset 24 -> rsp err=1, type=5 at N+5;
//     with DL stubbed silent -> same forced type 5, index 0.
//  5. rsp_ready_i held 0 for 5 cycles -> rsp_* stable, req_ready_o=0; new request accepted the cycle after the handshake.
//  6. rst_ni asserted mid-SCAN at offset 16 -> immediate IDLE, rsp_valid_o=0, offset=0;
//     the next request scans from 0.

Source files
------------

// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access encoding, window-sequencer states and error-type codes.
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } access_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    localparam logic [2:0] ERR_NOT_HIT = 3'h5;

endpackage

// File: rtl/rv_iopmp_dl_seq.sv
// Window sequencer: walks the entry table NUMBER_INSTANCES entries per cycle through the
// shared decision logic and returns one registered allow/error response per transaction.
module rv_iopmp_dl_seq
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned NUMBER_ENTRIES   = 32,
    parameter int unsigned NUMBER_INSTANCES = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  access_t     req_access_i,
    output logic        dl_enable_o,
    output logic [8:0]  dl_entry_offset_o,
    output access_t     dl_access_o,
    input  logic        dl_allow_i,
    input  logic        dl_err_i,
    input  logic [2:0]  dl_err_type_i,
    input  logic [15:0] dl_err_index_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_allow_o,
    output logic        rsp_err_o,
    output logic [2:0]  rsp_err_type_o,
    output logic [15:0] rsp_err_index_o
);

    localparam logic [8:0] LAST = 9'(NUMBER_ENTRIES - NUMBER_INSTANCES);
    localparam logic [8:0] STEP = 9'(NUMBER_INSTANCES);

    seq_state_e  state_q, state_d;
    logic [8:0]  offset_q, offset_d;
    access_t     access_q, access_d;
    logic        allow_q, allow_d;
    logic        err_q, err_d;
    logic [2:0]  err_type_q, err_type_d;
    logic [15:0] err_index_q, err_index_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            access_q    <= ACCESS_NONE;
            allow_q     <= 1'b0;
            err_q       <= 1'b0;
            err_type_q  <= '0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            access_q    <= access_d;
            allow_q     <= allow_d;
            err_q       <= err_d;
            err_type_q  <= err_type_d;
            err_index_q <= err_index_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        offset_d          = offset_q;
        access_d          = access_q;
        allow_d           = allow_q;
        err_d             = err_q;
        err_type_d        = err_type_q;
        err_index_d       = err_index_q;
        req_ready_o       = 1'b0;
        rsp_valid_o       = 1'b0;
        dl_enable_o       = 1'b0;
        dl_entry_offset_o = '0;
        dl_access_o       = ACCESS_NONE;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    access_d = req_access_i;
                    offset_d = '0;
                    if (enable_i) begin
                        state_d = SCAN;
                    end else begin
                        // IOPMP disabled: everything passes without touching the table
                        allow_d     = 1'b1;
                        err_d       = 1'b0;
                        err_type_d  = '0;
                        err_index_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            SCAN: begin
                dl_enable_o       = 1'b1;
                dl_entry_offset_o = offset_q;
                dl_access_o       = access_q;
                if (dl_allow_i || dl_err_i) begin
                    allow_d     = dl_allow_i;
                    err_d       = dl_err_i;
                    err_type_d  = dl_err_type_i;
                    err_index_d = dl_err_index_i;
                    state_d     = RESP;
                end else if (offset_q != LAST) begin
                    offset_d = offset_q + STEP;
                end else begin
                    // Last window silent: never let a transaction through undecided
                    allow_d     = 1'b0;
                    err_d       = 1'b1;
                    err_type_d  = ERR_NOT_HIT;
                    err_index_d = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    offset_d    = '0;
                    allow_d     = 1'b0;
                    err_d       = 1'b0;
                    err_type_d  = '0;
                    err_index_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_allow_o     = allow_q;
    assign rsp_err_o       = err_q;
    assign rsp_err_type_o  = err_type_q;
    assign rsp_err_index_o = err_index_q;

endmodule

// File: tb/tb_rv_iopmp_dl_seq.sv
// Directed bench for the window sequencer with a programmable single-window decision-logic stub.
module tb_rv_iopmp_dl_seq;
    import rv_iopmp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        req_valid;
    logic        req_ready;
    access_t     req_access;
    logic        dl_enable;
    logic [8:0]  dl_offset;
    access_t     dl_access;
    logic        dl_allow;
    logic        dl_err;
    logic [2:0]  dl_err_type;
    logic [15:0] dl_err_index;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_allow;
    logic        rsp_err;
    logic [2:0]  rsp_err_type;
    logic [15:0] rsp_err_index;

    // Stub: decides only in the window starting at stub_off, when stub_on is set
    logic        stub_on;
    logic [8:0]  stub_off;
    logic        stub_allow;
    logic [2:0]  stub_type;
    logic [15:0] stub_index;

    int checks = 0;
    int errors = 0;

    rv_iopmp_dl_seq #(
        .NUMBER_ENTRIES  (32),
        .NUMBER_INSTANCES(8)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enable_i         (enable),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_access_i     (req_access),
        .dl_enable_o      (dl_enable),
        .dl_entry_offset_o(dl_offset),
        .dl_access_o      (dl_access),
        .dl_allow_i       (dl_allow),
        .dl_err_i         (dl_err),
        .dl_err_type_i    (dl_err_type),
        .dl_err_index_i   (dl_err_index),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_allow_o      (rsp_allow),
        .rsp_err_o        (rsp_err),
        .rsp_err_type_o   (rsp_err_type),
        .rsp_err_index_o  (rsp_err_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dl_allow     = 1'b0;
        dl_err       = 1'b0;
        dl_err_type  = '0;
        dl_err_index = '0;
        if (dl_enable && stub_on && dl_offset == stub_off) begin
            dl_allow     = stub_allow;
            dl_err       = !stub_allow;
            dl_err_type  = stub_type;
            dl_err_index = stub_index;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_hs_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_hs_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic set_stub(input logic on, input logic [8:0] off, input logic allow,
                            input logic [2:0] etype, input logic [15:0] idx);
        stub_on    = on;
        stub_off   = off;
        stub_allow = allow;
        stub_type  = etype;
        stub_index = idx;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        req_valid  = 1'b0;
        req_access = ACCESS_NONE;
        rsp_ready  = 1'b0;
        set_stub(1'b0, 9'd0, 1'b0, 3'd0, 16'd0);
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_dl_enable", 32'(dl_enable), 32'd0);
        chk("rst_offset", 32'(dl_offset), 32'd0);
        chk("rst_rsp_fields", {rsp_allow, rsp_err, rsp_err_type, rsp_err_index}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1. Bypass: response one cycle after acceptance
        enable     = 1'b0;
        req_valid  = 1'b1;
        req_access = ACCESS_READ;
        tick();
        req_valid = 1'b0;
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_allow_err", {rsp_allow, rsp_err}, 32'b10);
        chk("t1_ready", 32'(req_ready), 32'd0);
        chk("t1_dl_enable", 32'(dl_enable), 32'd0);
        tick();
        chk("t1_hold_ready", 32'(req_ready), 32'd0);
        chk("t1_hold_valid", 32'(rsp_valid), 32'd1);
        handshake("t1");

        // 2. Allow in window 2; enable drop after acceptance must not matter
        set_stub(1'b1, 9'd16, 1'b1, 3'd0, 16'd0);
        enable     = 1'b1;
        req_valid  = 1'b1;
        req_access = ACCESS_READ;
        tick();
        req_valid = 1'b0;
        enable    = 1'b0;
        chk("t2_off0", 32'(dl_offset), 32'd0);
        chk("t2_dl_enable", 32'(dl_enable), 32'd1);
        chk("t2_dl_access", 32'(dl_access), 32'(ACCESS_READ));
        chk("t2_ready", 32'(req_ready), 32'd0);
        tick();
        chk("t2_off8", 32'(dl_offset), 32'd8);
        chk("t2_valid_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("t2_off16", 32'(dl_offset), 32'd16);
        tick();
        chk("t2_valid", 32'(rsp_valid), 32'd1);
        chk("t2_allow_err", {rsp_allow, rsp_err}, 32'b10);
        chk("t2_dl_idle", {dl_enable, dl_offset}, 32'd0);
        handshake("t2");

        // 3. Write denied in window 1 at entry 11
        set_stub(1'b1, 9'd8, 1'b0, 3'd2, 16'd11);
        enable     = 1'b1;
        req_valid  = 1'b1;
        req_access = ACCESS_WRITE;
        tick();
        req_valid = 1'b0;
        chk("t3_dl_access", 32'(dl_access), 32'(ACCESS_WRITE));
        tick();
        chk("t3_off8", 32'(dl_offset), 32'd8);
        tick();
        chk("t3_valid", 32'(rsp_valid), 32'd1);
        chk("t3_allow_err", {rsp_allow, rsp_err}, 32'b01);
        chk("t3_type", 32'(rsp_err_type), 32'd2);
        chk("t3_index", 32'(rsp_err_index), 32'd11);
        handshake("t3");

        // 4a. DL reports not-hit in the last window
        set_stub(1'b1, 9'd24, 1'b0, 3'd5, 16'd0);
        req_valid  = 1'b1;
        req_access = ACCESS_READ;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t4a_off_last", 32'(dl_offset), 32'd24);
        chk("t4a_valid_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("t4a_valid", 32'(rsp_valid), 32'd1);
        chk("t4a_fields", {rsp_allow, rsp_err, rsp_err_type}, 32'b0_1_101);
        handshake("t4a");

        // 4b. DL silent everywhere: forced not-hit, index 0
        set_stub(1'b0, 9'd0, 1'b0, 3'd0, 16'd0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t4b_off_last", 32'(dl_offset), 32'd24);
        tick();
        chk("t4b_valid", 32'(rsp_valid), 32'd1);
        chk("t4b_fields", {rsp_allow, rsp_err, rsp_err_type}, 32'b0_1_101);
        chk("t4b_index", 32'(rsp_err_index), 32'd0);
        chk("t4b_dl_idle", {dl_enable, dl_offset}, 32'd0);
        handshake("t4b");

        // 5. Back-pressure: response held; pending request waits for the handshake
        set_stub(1'b1, 9'd0, 1'b0, 3'd3, 16'd5);
        req_valid = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t5_hold_fields", {rsp_allow, rsp_err, rsp_err_type, rsp_err_index},
                {13'd0, 1'b0, 1'b1, 3'd3, 16'd5});
            chk("t5_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t5_idle_ready", 32'(req_ready), 32'd1);
        chk("t5_idle_valid", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("t5_next_bypass", {rsp_valid, rsp_allow, rsp_err}, 32'b110);
        handshake("t5");

        // 6. Reset in the middle of a scan
        set_stub(1'b0, 9'd0, 1'b0, 3'd0, 16'd0);
        enable    = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("t6_off16", 32'(dl_offset), 32'd16);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t6_rst_dl", {dl_enable, dl_offset}, 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_stub(1'b1, 9'd0, 1'b1, 3'd0, 16'd0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("t6_restart_off", 32'(dl_offset), 32'd0);
        chk("t6_restart_en", 32'(dl_enable), 32'd1);
        tick();
        chk("t6_rsp", {rsp_valid, rsp_allow, rsp_err}, 32'b110);
        handshake("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
